// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: bit timing, frame state encodings and the parity formula
// used by both uart_tx and uart_rx so one configuration drives both ends.
package uart_rx_pkg;

  // Bit period is UART_FULL_ETU+1 clocks (100 MHz system clock, 115200 baud).
  localparam logic [9:0] UART_FULL_ETU = 10'd867;
  localparam logic [9:0] UART_HALF_ETU = UART_FULL_ETU >> 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } uart_state_e;

  function automatic logic uart_parity(input logic [7:0] data, input logic even);
    return even ? ^data : ~^data;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-bit two-flop synchroniser with a configurable reset value, for any
// asynchronous input entering the clk domain.
module uart_sync #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // NOTE: sequential state uses non-blocking assignments so both flops sample
  // the pre-edge values; blocking here would collapse the chain to one flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronises din, qualifies the start bit at mid-bit, samples data,
// optional parity and stop bits at mid-bit, and strobes one byte per frame on valid.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int         DATA_BITS   = 8,
  parameter int         STOP_BITS   = 1,
  parameter logic       PARITY_EN   = 1'b1,
  parameter logic       PARITY_EVEN = 1'b1,
  parameter logic [9:0] FULL_ETU    = UART_FULL_ETU,
  parameter logic [9:0] HALF_ETU    = UART_HALF_ETU
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  logic        w_din_s;
  logic        r_din_q;
  uart_state_e r_state;
  uart_state_e w_state_nxt;
  logic [9:0]  r_etu_cnt;
  logic [3:0]  r_bit_cnt;
  logic [7:0]  r_shreg;
  logic        r_par_bit;
  logic        r_ferr_pend;
  logic        r_armed;

  logic [7:0]  r_data_out;
  logic        r_valid;
  logic        r_parity_err;
  logic        r_frame_err;
  logic        r_busy;

  logic w_fall;
  logic w_half_hit;
  logic w_full_hit;
  logic w_last_data;
  logic w_last_stop;
  logic w_par_calc;

  logic w_start_det;
  logic w_start_ok;
  logic w_glitch;
  logic w_shift;
  logic w_par_latch;
  logic w_stop_smp;
  logic w_done;

  // Idle-high line: synchroniser resets to 1 so reset release never looks like a start.
  uart_sync #(
    .WIDTH    (1),
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk    (clk),
    .rst    (rst),
    .i_async(din),
    .o_sync (w_din_s)
  );

  assign w_fall      = r_din_q & ~w_din_s;
  assign w_half_hit  = (r_etu_cnt == HALF_ETU);
  assign w_full_hit  = (r_etu_cnt == FULL_ETU);
  assign w_last_data = (r_bit_cnt == LAST_DATA);
  assign w_last_stop = (r_bit_cnt == LAST_STOP);
  assign w_par_calc  = uart_parity(r_shreg, PARITY_EVEN);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every signal assigned in always_comb gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (r_armed && w_fall) w_state_nxt = ST_START;
      ST_START: if (w_half_hit) w_state_nxt = w_din_s ? ST_IDLE : ST_DATA;
      ST_DATA:  if (w_full_hit && w_last_data) w_state_nxt = PARITY_EN ? ST_PAR : ST_STOP;
      ST_PAR:   if (w_full_hit) w_state_nxt = ST_STOP;
      ST_STOP:  if (w_full_hit && w_last_stop) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Per-state control strobes driving the datapath registers
  always_comb begin
    w_start_det = 1'b0;
    w_start_ok  = 1'b0;
    w_glitch    = 1'b0;
    w_shift     = 1'b0;
    w_par_latch = 1'b0;
    w_stop_smp  = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE:  w_start_det = r_armed && w_fall;
      ST_START: begin
        w_start_ok = w_half_hit && !w_din_s;
        w_glitch   = w_half_hit && w_din_s;
      end
      ST_DATA:  w_shift     = w_full_hit;
      ST_PAR:   w_par_latch = w_full_hit;
      ST_STOP:  begin
        w_stop_smp = w_full_hit;
        w_done     = w_full_hit && w_last_stop;
      end
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_din_q     <= 1'b1;
      r_etu_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_shreg     <= '0;
      r_par_bit   <= 1'b0;
      r_ferr_pend <= 1'b0;
      r_armed     <= 1'b1;
    end else begin
      r_din_q <= w_din_s;

      if (w_start_det || w_start_ok || w_shift || w_par_latch || w_stop_smp) begin
        r_etu_cnt <= '0;
      end else begin
        r_etu_cnt <= r_etu_cnt + 10'd1;
      end

      // Counter is reused: data bits first, then stop bits after leaving DATA.
      if (w_start_ok || (w_shift && w_last_data)) begin
        r_bit_cnt <= '0;
      end else if (w_shift || w_stop_smp) begin
        r_bit_cnt <= r_bit_cnt + 4'd1;
      end

      // Cleared at start so short frames leave zeros below the data for parity.
      if (w_start_det) begin
        r_shreg <= '0;
      end else if (w_shift) begin
        r_shreg <= {w_din_s, r_shreg[7:1]};
      end

      if (w_par_latch) begin
        r_par_bit <= w_din_s;
      end

      if (w_start_det) begin
        r_ferr_pend <= 1'b0;
      end else if (w_stop_smp && !w_din_s) begin
        r_ferr_pend <= 1'b1;
      end

      // A frame ending on a low line (break) must see the line high before re-arming.
      if (w_done) begin
        r_armed <= w_din_s;
      end else if (w_din_s) begin
        r_armed <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_out   <= '0;
      r_valid      <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_valid <= w_done;
      if (w_done) begin
        r_data_out   <= r_shreg >> (8 - DATA_BITS);
        r_parity_err <= PARITY_EN && (r_par_bit != w_par_calc);
        r_frame_err  <= r_ferr_pend | ~w_din_s;
      end
      if (w_start_det) begin
        r_busy <= 1'b1;
      end else if (w_glitch || w_done) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign data_out   = r_data_out;
  assign valid      = r_valid;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign busy       = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: four receiver configurations driven by a
// bench-side serial line generator, checked against a frame-level expectation queue.
module tb_uart_rx;

  localparam int         P    = 16;
  localparam logic [9:0] FULL = 10'd15;
  localparam logic [9:0] HALF = 10'd7;

  typedef struct {
    int         dut;
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  // Per-instance frame format: 0=8E1, 1=8O1, 2=8N1, 3=7N2
  int cfg_bits [4] = '{8, 8, 8, 7};
  bit cfg_par  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  bit cfg_even [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  int cfg_stop [4] = '{1, 1, 1, 2};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din  [4];
  logic [7:0] dout [4];
  logic       vld  [4];
  logic       perr [4];
  logic       ferr [4];
  logic       bsy  [4];

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   vcount [4];
  int   vcyc   [4];
  int   fstart [4];
  bit   mon_en = 1'b0;
  exp_t exp_q [$];

  logic [9:0] prev_hold [4];
  bit         prev_vld  [4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_EN(1'b1), .PARITY_EVEN(1'b1),
            .FULL_ETU(FULL), .HALF_ETU(HALF)) u_8e1 (
    .clk(clk), .rst(rst), .din(din[0]), .data_out(dout[0]), .valid(vld[0]),
    .parity_err(perr[0]), .frame_err(ferr[0]), .busy(bsy[0]));

  uart_rx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_EN(1'b1), .PARITY_EVEN(1'b0),
            .FULL_ETU(FULL), .HALF_ETU(HALF)) u_8o1 (
    .clk(clk), .rst(rst), .din(din[1]), .data_out(dout[1]), .valid(vld[1]),
    .parity_err(perr[1]), .frame_err(ferr[1]), .busy(bsy[1]));

  uart_rx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_EN(1'b0), .PARITY_EVEN(1'b1),
            .FULL_ETU(FULL), .HALF_ETU(HALF)) u_8n1 (
    .clk(clk), .rst(rst), .din(din[2]), .data_out(dout[2]), .valid(vld[2]),
    .parity_err(perr[2]), .frame_err(ferr[2]), .busy(bsy[2]));

  uart_rx #(.DATA_BITS(7), .STOP_BITS(2), .PARITY_EN(1'b0), .PARITY_EVEN(1'b1),
            .FULL_ETU(FULL), .HALF_ETU(HALF)) u_7n2 (
    .clk(clk), .rst(rst), .din(din[3]), .data_out(dout[3]), .valid(vld[3]),
    .parity_err(perr[3]), .frame_err(ferr[3]), .busy(bsy[3]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Strobe scoreboard plus hold/strobe-shape checks, every cycle once out of reset.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      for (int k = 0; k < 4; k++) begin
        if (vld[k]) begin
          vcount[k]++;
          vcyc[k] = cyc;
          check($sformatf("dut%0d_valid_gap", k), 32'(prev_vld[k]), 32'd0);
          check($sformatf("dut%0d_busy_at_valid", k), 32'(bsy[k]), 32'd0);
          if (exp_q.size() == 0) begin
            check($sformatf("dut%0d_unexpected_strobe", k), 32'(vld[k]), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("dut%0d_strobe_owner", k), 32'(k), 32'(e.dut));
            check($sformatf("dut%0d_data", k), 32'(dout[k]), 32'(e.data));
            check($sformatf("dut%0d_parity_err", k), 32'(perr[k]), 32'(e.perr));
            check($sformatf("dut%0d_frame_err", k), 32'(ferr[k]), 32'(e.ferr));
          end
        end else if (!rst) begin
          check($sformatf("dut%0d_hold", k), 32'({dout[k], perr[k], ferr[k]}),
                32'(prev_hold[k]));
        end
        prev_hold[k] = {dout[k], perr[k], ferr[k]};
        prev_vld[k]  = vld[k];
      end
    end
  end

  task automatic hold(input int d, input logic v, input int n);
    din[d] = v;
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame for instance d starting at the current negedge and records
  // what the receiver must report for it.
  task automatic send_frame(input int d, input logic [7:0] data, input bit flip_par,
                            input bit stop_low, input bit push);
    logic [7:0] dm;
    int         ones;
    logic       pb;
    exp_t       e;
    dm   = data & 8'((1 << cfg_bits[d]) - 1);
    ones = $countones(dm);
    pb   = cfg_even[d] ? (ones % 2 == 1) : (ones % 2 == 0);
    pb   = pb ^ flip_par;
    if (push) begin
      e.dut  = d;
      e.data = dm;
      e.perr = cfg_par[d] && flip_par;
      e.ferr = stop_low;
      exp_q.push_back(e);
    end
    fstart[d] = cyc;
    hold(d, 1'b0, P);
    for (int i = 0; i < cfg_bits[d]; i++) hold(d, dm[i], P);
    if (cfg_par[d]) hold(d, pb, P);
    for (int i = 0; i < cfg_stop[d]; i++) hold(d, !stop_low, P);
  endtask

  initial begin
    int  vbefore;
    bit  saw_busy;
    for (int k = 0; k < 4; k++) begin
      din[k]    = 1'b1;
      vcount[k] = 0;
      vcyc[k]   = 0;
      fstart[k] = 0;
    end
    rst = 1'b1;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 4; k++)
      check($sformatf("dut%0d_reset_outputs", k),
            32'({dout[k], vld[k], perr[k], ferr[k], bsy[k]}), 32'd0);
    for (int k = 0; k < 4; k++) begin
      prev_hold[k] = '0;
      prev_vld[k]  = 1'b0;
    end
    rst    = 1'b0;
    mon_en = 1'b1;
    repeat (4) @(negedge clk);

    // 8E1 0x55
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1);
    hold(0, 1'b1, 4);
    check("e1_count", 32'(vcount[0]), 32'd1);
    check("e1_data_lit", 32'(dout[0]), 32'h55);
    check("e1_flags_lit", 32'({perr[0], ferr[0]}), 32'd0);
    check("e1_busy_after", 32'(bsy[0]), 32'd0);

    // 8O1 0xA3 with inverted parity bit
    send_frame(1, 8'hA3, 1'b1, 1'b0, 1'b1);
    hold(1, 1'b1, 4);
    check("o1_count", 32'(vcount[1]), 32'd1);
    check("o1_data_lit", 32'(dout[1]), 32'hA3);
    check("o1_perr_lit", 32'(perr[1]), 32'd1);
    check("o1_ferr_lit", 32'(ferr[1]), 32'd0);

    // 8N1 0x3C with low stop bit, then break for 3 bit periods
    send_frame(2, 8'h3C, 1'b0, 1'b1, 1'b1);
    hold(2, 1'b0, 3 * P);
    check("brk_count", 32'(vcount[2]), 32'd1);
    check("brk_data_lit", 32'(dout[2]), 32'h3C);
    check("brk_ferr_lit", 32'(ferr[2]), 32'd1);
    hold(2, 1'b1, 2 * P);
    send_frame(2, 8'h7E, 1'b0, 1'b0, 1'b1);
    hold(2, 1'b1, 4);
    check("n1_count", 32'(vcount[2]), 32'd2);
    check("n1_data_lit", 32'(dout[2]), 32'h7E);
    check("n1_flags_lit", 32'({perr[2], ferr[2]}), 32'd0);
    // 9.5*P + 3 clocks from the line's falling edge
    check("n1_latency", 32'(vcyc[2] - fstart[2]), 32'd155);

    // Half-of-half-bit glitch on an idle line
    hold(2, 1'b0, 3);
    din[2]   = 1'b1;
    saw_busy = 1'b0;
    for (int i = 0; i < 2 * P; i++) begin
      @(negedge clk);
      if (bsy[2]) saw_busy = 1'b1;
    end
    check("glitch_busy_pulse", 32'(saw_busy), 32'd1);
    check("glitch_busy_after", 32'(bsy[2]), 32'd0);
    check("glitch_no_strobe", 32'(vcount[2]), 32'd2);

    // Reset in the middle of data bit 4 of 0xF0
    vbefore = vcount[2];
    fork
      send_frame(2, 8'hF0, 1'b0, 1'b0, 1'b0);
      begin
        repeat (5 * P + P / 2) @(negedge clk);
        check("rst_busy_before", 32'(bsy[2]), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_outputs_zero",
              32'({dout[2], vld[2], perr[2], ferr[2], bsy[2]}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
      end
    join
    hold(2, 1'b1, 4);
    check("rst_no_strobe", 32'(vcount[2]), 32'(vbefore));
    send_frame(2, 8'h81, 1'b0, 1'b0, 1'b1);
    hold(2, 1'b1, 4);
    check("after_rst_data_lit", 32'(dout[2]), 32'h81);

    // 7N2 back-to-back frames
    send_frame(3, 8'h00, 1'b0, 1'b0, 1'b1);
    send_frame(3, 8'h7F, 1'b0, 1'b0, 1'b1);
    send_frame(3, 8'h2A, 1'b0, 1'b0, 1'b1);
    hold(3, 1'b1, 4);
    check("n2_count", 32'(vcount[3]), 32'd3);
    check("n2_data_lit", 32'(dout[3]), 32'h2A);
    check("n2_flags_lit", 32'({perr[3], ferr[3]}), 32'd0);

    check("pending_frames", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver paired with the team's `uart_tx`. It sits directly downstream of the transmit line, at the FPGA pin or in loopback. It synchronises the asynchronous `din` line, detects and qualifies start bits, and samples each bit at mid-bit. It delivers one byte per frame, with parity and framing status, on a single-cycle `valid` strobe. Frame format and bit timing come from the same parameters and shared ETU constants as the transmitter, so one configuration drives both ends.

## Interface
- `DATA_BITS`, 8: data bits per frame, 5..8, LSB first.
- `STOP_BITS`, 1: stop bits checked, 1 or 2.
- `PARITY_EN`, 1'b1: 1 = parity bit follows the data bits.
- `PARITY_EVEN`, 1'b1: 1 = even parity (bit = ^data), 0 = odd parity (bit = ~^data).

Ports:
- `clk` input 1: system clock.
- `rst` input 1: reset, synchronous, active-high. Clock is `clk`.
- `din` input 1: asynchronous serial line, idle high.
- `data_out` output 8: last received data, right-aligned, unused MSBs 0, held until the next frame completes.
- `valid` output 1: one-cycle strobe, frame complete.
- `parity_err` output 1: parity mismatch for the frame reported by `valid`. Held with `data_out`.
- `frame_err` output 1: a stop bit sampled low. Held with `data_out`.
- `busy` output 1: high from start-bit detection until return to IDLE.

## Operation
- `din` passes through a 2-flop synchroniser (reset value 1) giving `din_s`, plus one delay flop `din_q`.
- Bit period P = `UART_FULL_ETU`+1 clocks, identical to `uart_tx`. `etu_cnt` is 10 bits, +1 every cycle, cleared as listed below.
- IDLE:
  - Requires `armed`, meaning `din_s`=1 has been seen since the last frame.
  - Falling edge (`din_q`=1, `din_s`=0) → `etu_cnt`<=0, `busy`<=1, go to START.
- START: at `etu_cnt`==`UART_HALF_ETU`:
  - `din_s`=0 → `etu_cnt`<=0, `bit_cnt`<=0, go to DATA.
  - `din_s`=1 → glitch: go to IDLE, `busy`<=0, no strobe.
- DATA: at `etu_cnt`==`UART_FULL_ETU`:
  - Shift `din_s` into `shreg` MSB, `bit_cnt`+1, `etu_cnt`<=0.
  - After `DATA_BITS` samples → PAR if `PARITY_EN`, else STOP.
- PAR: at full ETU, latch the sampled bit, `etu_cnt`<=0, go to STOP.
- STOP:
  - At each full ETU, sample `din_s`. Any low sample sets the pending frame error. `etu_cnt`<=0.
  - After `STOP_BITS` samples:
    - `data_out` <= `shreg`>>(8-`DATA_BITS`).
    - `parity_err` <= `PARITY_EN` && (sampled bit != computed parity).
    - `frame_err` <= pending frame error.
    - `valid`<=1, `busy`<=0, go to IDLE.
- `valid` and the error flags are reported even on an errored frame; the consumer decides to drop the byte.
- After a frame error with `din` still low (break), `armed` is cleared. No new start is accepted until `din_s` returns high.
- Reset mid-frame aborts the frame. No strobe is produced, and every output takes its reset value.
- Undefined state encodings return to IDLE.

## Timing
- Reset values: `data_out`=0, `valid`=0, `parity_err`=0, `frame_err`=0, `busy`=0, state IDLE, `armed`=1.
- Start detect occurs 2 clocks (synchroniser) after the line edge at `din`. `busy` rises 1 clock after detect.
- Sample points:
  - Start bit qualified at detect + `UART_HALF_ETU`+1 clocks.
  - Each following bit sampled P clocks after the previous sample.
- `valid` is high in the single cycle after the final stop-bit sample edge. With 8N1 this is about 9.5·P + 3 clocks after the falling edge at the pin.
- Back-to-back frames: the receiver is back in IDLE half a bit before the line's stop bit ends, so `uart_tx` at full rate never loses a frame.
- `valid` never asserts for two consecutive cycles. `data_out` and the flags change only in the cycle `valid` rises.

## Structure
- Add `UART_HALF_ETU` (= `UART_FULL_ETU`/2) to the shared `uart_defs` include next to `UART_FULL_ETU`. Put state encodings (IDLE/START/DATA/PAR/STOP) there as 3-bit localparams-by-define, so TX and RX share the bit-timing definitions.
- Sub-module `uart_sync`: parameterised 2-flop synchroniser with reset value. It is reusable for any other asynchronous input.
- Parity is computed combinationally from `shreg`, using the same formula as the transmitter.

## Test plan
- Loopback `uart_tx`→`uart_rx`, 8E1, send 0x55 → exactly one `valid`; `data_out`=0x55; `parity_err`=0; `frame_err`=0; `busy` low afterwards.
- Bench-driven frame 0xA3, 8O1, with parity bit inverted → `valid`, `data_out`=0xA3, `parity_err`=1, `frame_err`=0.
- 8N1 frame 0x3C with stop bit held low, then line low for 3·P → `frame_err`=1 on the strobe. No second `valid` until the line returns high and a real frame 0x7E arrives, giving `data_out`=0x7E with both flags clear.
- Low glitch of `UART_HALF_ETU`/2 clocks on idle line → `busy` pulses, no `valid`, state returns to IDLE.
- `rst` asserted during data bit 4 of 0xF0 → all outputs 0 next cycle and no strobe. The following frame 0x81 is received correctly.
- `STOP_BITS`=2, `PARITY_EN`=0, `DATA_BITS`=7, back-to-back 0x00,0x7F,0x2A from `uart_tx` → three strobes with exactly those values, no errors.
